// File: rtl/alu_issue_ctrl.sv
// Handshaked, multi-cycle issue controller in front of the combinational 32-bit ALU.
// Optional response statistics counters are enabled with `define ALU_ISSUE_STATS_EN.
module alu_issue_ctrl #(
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  // Valid/ready handshakes: a transfer occurs on a rising clk edge where valid
  // and ready are both high; the source holds its payload stable until then.
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [63:0]      alu_result,
  input  logic             alu_v,
  input  logic             alu_c,
  input  logic             alu_z,
  input  logic             alu_n,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [63:0]      rsp_data,
  output logic [3:0]       rsp_flags,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic [1:0]       dbg_state
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [15:0]      stat_ops,
  output logic [15:0]      stat_err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_RSVD = 4'b1111;
  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [31:0]        alu_a_q, alu_a_d;
  logic [31:0]        alu_b_q, alu_b_d;
  logic [3:0]         alu_ctrl_q, alu_ctrl_d;
  logic [63:0]        rsp_data_q, rsp_data_d;
  logic [3:0]         rsp_flags_q, rsp_flags_d;
  logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;
  logic               rsp_err_q, rsp_err_d;
  logic               accept;
  logic               capture;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (cmd_valid) state_d = (cmd_op == OP_RSVD) ? S_RESP : S_EXEC;
      S_EXEC: if (cnt_q == 4'd0) state_d = S_RESP;
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / strobe logic
  always_comb begin
    cmd_ready = (state_q == S_IDLE);
    rsp_valid = (state_q == S_RESP);
    accept    = cmd_ready && cmd_valid;
    capture   = (state_q == S_EXEC) && (cnt_q == 4'd0);
    dbg_state = state_q;
  end

  // Datapath next values; ALU inputs change only on acceptance so they never glitch mid-execute.
  always_comb begin
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_ctrl_d  = alu_ctrl_q;
    rsp_data_d  = rsp_data_q;
    rsp_flags_d = rsp_flags_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_err_d   = rsp_err_q;
    if (accept) begin
      alu_a_d    = cmd_a;
      alu_b_d    = cmd_b;
      alu_ctrl_d = cmd_op;
      rsp_tag_d  = cmd_tag;
      cnt_d      = (cmd_op == OP_MUL) ? MUL_CNT : 4'd0;
      if (cmd_op == OP_RSVD) begin
        rsp_data_d  = 64'd0;
        rsp_flags_d = 4'd0;
        rsp_err_d   = 1'b1;
      end
    end else if (capture) begin
      rsp_data_d  = alu_result;
      rsp_flags_d = {alu_v, alu_c, alu_z, alu_n};
      rsp_err_d   = 1'b0;
    end else if (state_q == S_EXEC) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= 4'd0;
      alu_a_q     <= 32'd0;
      alu_b_q     <= 32'd0;
      alu_ctrl_q  <= 4'd0;
      rsp_data_q  <= 64'd0;
      rsp_flags_q <= 4'd0;
      rsp_tag_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_ctrl_q  <= alu_ctrl_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_ctrl  = alu_ctrl_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_flags = rsp_flags_q;
  assign rsp_tag   = rsp_tag_q;
  assign rsp_err   = rsp_err_q;

`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] stat_ops_q, stat_ops_d;
  logic [15:0] stat_err_q, stat_err_d;
  logic        rsp_hs;

  // Counters wrap naturally at 16 bits.
  always_comb begin
    rsp_hs     = rsp_valid && rsp_ready;
    stat_ops_d = stat_ops_q;
    stat_err_d = stat_err_q;
    if (rsp_hs) begin
      stat_ops_d = stat_ops_q + 16'd1;
      if (rsp_err_q) stat_err_d = stat_err_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops_q <= 16'd0;
      stat_err_q <= 16'd0;
    end else begin
      stat_ops_q <= stat_ops_d;
      stat_err_q <= stat_err_d;
    end
  end

  assign stat_ops = stat_ops_q;
  assign stat_err = stat_err_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU model on the alu_* port, queue scoreboard on responses.
module tb_alu_issue_ctrl;
  localparam int MUL_LAT = 2;
  localparam int TAG_W   = 4;
  localparam int EXP_W   = TAG_W + 1 + 4 + 64;

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_op;
  logic [31:0]      cmd_a, cmd_b;
  logic [TAG_W-1:0] cmd_tag;
  logic [31:0]      alu_a, alu_b;
  logic [3:0]       alu_ctrl;
  logic [63:0]      alu_result;
  logic             alu_v, alu_c, alu_z, alu_n;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [63:0]      rsp_data;
  logic [3:0]       rsp_flags;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;
  logic [1:0]       dbg_state;
`ifdef ALU_ISSUE_STATS_EN
  logic [15:0]      stat_ops, stat_err;
  int               exp_ops = 0;
  int               exp_err = 0;
`endif

  logic [EXP_W-1:0] exp_q[$];
  int               n_pass = 0;
  int               n_total = 0;

  alu_issue_ctrl #(.MUL_LAT(MUL_LAT), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_v(alu_v), .alu_c(alu_c), .alu_z(alu_z), .alu_n(alu_n),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
    .dbg_state(dbg_state)
`ifdef ALU_ISSUE_STATS_EN
    , .stat_ops(stat_ops), .stat_err(stat_err)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ALU stand-in: returns {V,C,Z,N,result}.
  function automatic logic [67:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    logic        v;
    v = 1'b0;
    case (op)
      4'h0: begin
        r = {32'd0, a} + {32'd0, b};
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      4'h1: r = {32'd0, a} - {32'd0, b};
      4'h2: r = {32'd0, a} * {32'd0, b};
      4'h3: r = {32'd0, a & b};
      4'h4: r = {32'd0, a | b};
      4'h5: r = {32'd0, a ^ b};
      default: r = {a, b};
    endcase
    return {v, r[32], (r == 64'd0), r[63], r};
  endfunction

  assign {alu_v, alu_c, alu_z, alu_n, alu_result} = alu_fn(alu_ctrl, alu_a, alu_b);

  function automatic logic [EXP_W-1:0] expect_of(input logic [3:0] op, input logic [31:0] a,
                                                  input logic [31:0] b, input logic [TAG_W-1:0] tag);
    if (op == 4'hF) return {tag, 1'b1, 4'd0, 64'd0};
    return {tag, 1'b0, alu_fn(op, a, b)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, act, exp);
  endtask

  // Scoreboard: pop on every response handshake
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_tag", 64'(rsp_tag), 64'(e[EXP_W-1 -: TAG_W]));
        chk("rsp_err", 64'(rsp_err), 64'(e[68]));
        chk("rsp_flags", 64'(rsp_flags), 64'(e[67:64]));
        chk("rsp_data", rsp_data, e[63:0]);
`ifdef ALU_ISSUE_STATS_EN
        exp_ops++;
        if (e[68]) exp_err++;
`endif
      end
    end
  end

  // Driver: call at posedge+1; returns at posedge+1 with the DUT idle again.
  task automatic run_cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag, input int hold);
    int lat;
    int last;
    logic [EXP_W-1:0] e;
    lat  = (op == 4'hF) ? 1 : (op == 4'h2) ? 1 + MUL_LAT : 2;
    last = lat + hold;
    e    = expect_of(op, a, b, tag);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_tag   = tag;
    rsp_ready = 1'b0;
    exp_q.push_back(e);
    @(negedge clk);
    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    for (int c = 1; c <= last; c++) begin
      @(posedge clk);
      #1;
      // Competing traffic that must be ignored while busy
      cmd_valid = 1'b1;
      cmd_op    = 4'($urandom_range(0, 15));
      cmd_a     = $urandom;
      cmd_b     = $urandom;
      cmd_tag   = TAG_W'($urandom);
      rsp_ready = (c == last) || ((c < lat) && ($urandom_range(0, 1) == 1));
      @(negedge clk);
      chk("rsp_valid_timing", 64'(rsp_valid), 64'(c >= lat));
      chk("cmd_ready_busy", 64'(cmd_ready), 64'd0);
      chk("alu_ctrl_stable", 64'(alu_ctrl), 64'(op));
      chk("alu_a_stable", 64'(alu_a), 64'(a));
      chk("alu_b_stable", 64'(alu_b), 64'(b));
      if (c >= lat) chk("rsp_data_held", rsp_data, e[63:0]);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("rsp_valid_drop", 64'(rsp_valid), 64'd0);
    chk("cmd_ready_back", 64'(cmd_ready), 64'd1);
    chk("rsp_tag_kept", 64'(rsp_tag), 64'(tag));
    chk("rsp_data_kept", rsp_data, e[63:0]);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({pfx, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    chk({pfx, "_rsp_data"}, rsp_data, 64'd0);
    chk({pfx, "_rsp_flags"}, 64'(rsp_flags), 64'd0);
    chk({pfx, "_rsp_tag"}, 64'(rsp_tag), 64'd0);
    chk({pfx, "_rsp_err"}, 64'(rsp_err), 64'd0);
    chk({pfx, "_alu_a"}, 64'(alu_a), 64'd0);
    chk({pfx, "_alu_b"}, 64'(alu_b), 64'd0);
    chk({pfx, "_alu_ctrl"}, 64'(alu_ctrl), 64'd0);
  endtask

  initial begin
    logic [3:0] op_tab[8];
    op_tab = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hF, 4'h9};
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 4'd0;
    cmd_a     = 32'd0;
    cmd_b     = 32'd0;
    cmd_tag   = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("por");
    chk("por_state", 64'(dbg_state), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed cases
    run_cmd(4'h0, 32'h0000_0005, 32'h0000_0003, 4'd3, 0);
    chk("add_const", rsp_data, 64'h8);
    run_cmd(4'h2, 32'hFFFF_FFFF, 32'h0000_0002, 4'd5, 0);
    chk("mul_const", rsp_data, 64'h1_FFFF_FFFE);
    run_cmd(4'hF, 32'h1234_5678, 32'h9ABC_DEF0, 4'd9, 0);
    chk("rsvd_err", 64'(rsp_err), 64'd1);
    chk("rsvd_tag", 64'(rsp_tag), 64'd9);
    run_cmd(4'h1, 32'd10, 32'd3, 4'd4, 5);
    chk("sub_const", rsp_data, 64'h7);
    run_cmd(4'h0, 32'hFFFF_FFFF, 32'h0000_0001, 4'd1, 1);
    chk("add_carry_const", rsp_data, 64'h1_0000_0000);

    // Reset in the middle of a multiply
    cmd_valid = 1'b1;
    cmd_op    = 4'h2;
    cmd_a     = 32'h0000_1234;
    cmd_b     = 32'h0000_0100;
    cmd_tag   = 4'd6;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_exec_state", 64'(dbg_state), 64'd1);
    rst_n     = 1'b0;
    cmd_valid = 1'b1;
    #1;
    chk_reset_outputs("rst_exec");
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_no_accept", 64'(rsp_valid), 64'd0);
    cmd_valid = 1'b0;
    rst_n     = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_no_rsp", 64'(rsp_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    run_cmd(4'h0, 32'd100, 32'd23, 4'd2, 0);
    chk("post_rst_add", rsp_data, 64'd123);

    // Random mix with random backpressure
    for (int i = 0; i < 12; i++) begin
      run_cmd(op_tab[$urandom_range(0, 7)], $urandom, $urandom, TAG_W'($urandom), $urandom_range(0, 2));
    end

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
`ifdef ALU_ISSUE_STATS_EN
    chk("stat_ops", 64'(stat_ops), 64'(exp_ops));
    chk("stat_err", 64'(stat_err), 64'(exp_err));
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequential initiator for the combinational 32-bit ALU: accepts operation commands over a valid/ready port, registers operands and the 4-bit ALU control code onto the ALU inputs, waits the required execute cycles and captures the 64-bit result plus V/C/Z/N flags into a response register. It sits between the CORDIC sequencer/decoder and the ALU, making the ALU usable as a handshaked, multi-cycle-safe resource.

## Interface
- MUL_LAT, 2: execute cycles for the multiply op (4'b0010); legal range 1..15.
- TAG_W, 4: width of the command/response tag.
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_op  input  4  ALU control code.
- cmd_a, cmd_b  input  32  operands.
- cmd_tag  input  TAG_W  returned unchanged with the response.
- alu_a, alu_b  output  32  registered operands to the ALU.
- alu_ctrl  output  4  registered ALU control code.
- alu_result  input  64  ALU result.
- alu_v, alu_c, alu_z, alu_n  input  1  ALU flags.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer takes the response.
- rsp_data  output  64  captured result.
- rsp_flags  output  4  captured {V,C,Z,N}.
- rsp_tag  output  TAG_W  tag of the command.
- rsp_err  output  1  command used reserved op 4'b1111.

## Operation
- States: IDLE, EXEC, RESP. cmd_ready = (state==IDLE); rsp_valid = (state==RESP).
- IDLE: on cmd_valid&cmd_ready, register cmd_a/cmd_b/cmd_op into alu_a/alu_b/alu_ctrl, cmd_tag into rsp_tag.
  - op 4'b1111: go RESP directly; rsp_data=0, rsp_flags=0, rsp_err=1; alu_* registers still loaded.
  - op 4'b0010: go EXEC, wait counter loaded with MUL_LAT-1.
  - any other op: go EXEC, counter loaded with 0.
- EXEC: counter>0 -> decrement; counter==0 -> capture alu_result into rsp_data, {alu_v,alu_c,alu_z,alu_n} into rsp_flags, rsp_err=0, go RESP.
- RESP: rsp_* held stable while rsp_valid&!rsp_ready; on rsp_ready go IDLE. rsp_data/flags/tag/err keep last values after handshake.
- alu_a/alu_b/alu_ctrl stay constant from acceptance until next acceptance (ALU inputs never glitch during EXEC).
- No overlap: new command accepted only in IDLE; cmd_* ignored in EXEC/RESP.
- Counter width 4 bits; no wrap possible within legal MUL_LAT.

## Timing
- Reset (rst_n low, any time, including mid-EXEC or mid-RESP): state IDLE immediately; cmd_ready=1 after reset only once rst_n deasserted (cmd_ready reflects IDLE, so 1 during reset is permitted; bench checks it is 1 and no accept before rst_n high); rsp_valid=0, rsp_data=0, rsp_flags=0, rsp_tag=0, rsp_err=0, alu_a=alu_b=0, alu_ctrl=0. In-flight command discarded, no response.
- Accept sampled at end of cycle 0. Non-multiply: rsp_valid high from cycle 2. Multiply: from cycle 1+MUL_LAT. Reserved: from cycle 1.
- rsp_ready high in the first RESP cycle: rsp_valid low next cycle, cmd_ready high that same cycle; best throughput one non-mul command per 3 cycles.
- rsp_ready asserted while rsp_valid low has no effect.

## Configuration
- ALU_ISSUE_STATS_EN defined: adds outputs stat_ops[15:0] (count of response handshakes, all ops) and stat_err[15:0] (count of handshakes with rsp_err=1); both reset to 0 asynchronously, increment on rsp_valid&rsp_ready, wrap 16'hFFFF->0.
- Not defined: ports and counters absent; all other behaviour identical.

## Test plan
- Add: op 0000, a=32'h0000_0005, b=32'h0000_0003, tag=3, rsp_ready=1 -> rsp_valid in cycle 2, rsp_data=64'h8 (as given by ALU), rsp_tag=3, rsp_err=0, one-cycle pulse.
- Multiply, MUL_LAT=2: op 0010, a=32'hFFFF_FFFF, b=32'h2 -> rsp_valid in cycle 3, rsp_data=64'h1_FFFF_FFFE; alu_ctrl=0010 stable cycles 1-3.
- Reserved op 1111, tag=9 -> rsp_valid in cycle 1, rsp_data=0, rsp_flags=0, rsp_err=1, rsp_tag=9; with STATS_EN stat_err=1.
- Backpressure: sub op 0001 a=10 b=3, rsp_ready low 5 cycles -> rsp_valid and rsp_data=64'h7 held; cmd_ready=0 and a second cmd_valid ignored until handshake.
- Reset mid-EXEC of multiply (MUL_LAT=4), rst_n low in cycle 2 -> all outputs zero immediately, no response after release; next add completes normally.
- STATS_EN wrap: preload via 65 536 completed commands -> stat_ops returns to 0.
